// File: rtl/seq_comparator.sv
// seq_comparator: slice-serial magnitude comparator, MSB slice first.
// Compares A and B CHUNK bits per cycle, signed or unsigned, and reports
// one-hot lt/eq/gt plus an SLT-style result word.
// Optional feature macro: CMP_EARLY_EXIT_EN (stop at the first differing
// slice). When undefined, every compare takes exactly N cycles.
module seq_comparator #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [WIDTH-1:0] out
);
    localparam int unsigned N = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic [CHUNK-1:0]  sa, sb;
    logic              s_lt, s_gt;

    // Select the current slice; in signed mode the top slice gets its MSB flipped
    // so an unsigned compare of it orders two's-complement values correctly.
    always_comb begin
        sa = a_q[idx_q*CHUNK +: CHUNK];
        sb = b_q[idx_q*CHUNK +: CHUNK];
        if (sgn_q && (idx_q == IdxTop)) begin
            sa[CHUNK-1] = ~sa[CHUNK-1];
            sb[CHUNK-1] = ~sb[CHUNK-1];
        end
    end

    assign s_lt = (sa < sb);
    assign s_gt = (sa > sb);

`ifndef CMP_EARLY_EXIT_EN
    // Sticky verdict: the first differing slice wins, later slices cannot override it.
    logic dec_q, dec_d, vlt_q, vlt_d, vgt_q, vgt_d;
    logic now_lt, now_gt;

    // Sticky verdict next-state; cleared on accept.
    always_comb begin
        dec_d = dec_q;
        vlt_d = vlt_q;
        vgt_d = vgt_q;
        if (state_q == StIdle && in_valid) begin
            dec_d = 1'b0;
            vlt_d = 1'b0;
            vgt_d = 1'b0;
        end else if (state_q == StRun && !dec_q && (s_lt || s_gt)) begin
            dec_d = 1'b1;
            vlt_d = s_lt;
            vgt_d = s_gt;
        end
        now_lt = dec_q ? vlt_q : s_lt;
        now_gt = dec_q ? vgt_q : s_gt;
    end

    // Sticky verdict registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
            vlt_q <= 1'b0;
            vgt_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
            vlt_q <= vlt_d;
            vgt_q <= vgt_d;
        end
    end
`endif

    // FSM next-state, operand latch and result flags.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = is_signed;
                    idx_d   = IdxTop;
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef CMP_EARLY_EXIT_EN
                if (s_lt || s_gt) begin
                    lt_d    = s_lt;
                    gt_d    = s_gt;
                    eq_d    = 1'b0;
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`else
                if (idx_q == '0) begin
                    lt_d    = now_lt;
                    gt_d    = now_gt;
                    eq_d    = ~(now_lt | now_gt);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`endif
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= IdxTop;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign out       = {{(WIDTH-1){1'b0}}, lt_q};

endmodule

// File: tb/tb_seq_comparator.sv
// Testbench for seq_comparator (WIDTH=64, CHUNK=8): directed cases plus
// randomized compares checked against a behavioural model.
module tb_seq_comparator;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned N = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             is_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             lt, eq, gt;
    logic [WIDTH-1:0] out;

    int n_chk = 0;
    int n_err = 0;

    seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .lt(lt), .eq(eq), .gt(gt), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected latency: position of first differing slice from the top.
    function automatic int exp_lat(input logic [63:0] x, input logic [63:0] y);
`ifdef CMP_EARLY_EXIT_EN
        for (int k = 1; k <= int'(N); k++) begin
            if (x[(int'(N) - k)*CHUNK +: CHUNK] != y[(int'(N) - k)*CHUNK +: CHUNK]) return k;
        end
        return N;
`else
        return N;
`endif
    endfunction

    // One full transaction: accept, wait for result, hold for bp cycles, retire.
    task automatic do_cmp(input logic [63:0] x, input logic [63:0] y, input logic s,
                          input int bp);
        logic e_lt, e_gt, e_eq;
        int   lat;
        bit   seen;
        if (s) begin
            e_lt = ($signed(x) < $signed(y));
            e_gt = ($signed(x) > $signed(y));
        end else begin
            e_lt = (x < y);
            e_gt = (x > y);
        end
        e_eq = (x == y);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs: latched operands must not follow them.
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; is_signed = 1'($urandom);
        lat = 0;
        seen = 0;
        while (!seen && lat < int'(2*N + 4)) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1;
            else check("in_ready_busy", 64'(in_ready), 64'd0);
        end
        if (!seen) begin
            check("timeout", 64'(out_valid), 64'd1);
            return;
        end
        check("latency", 64'(lat), 64'(exp_lat(x, y)));
        check("lt", 64'(lt), 64'(e_lt));
        check("eq", 64'(eq), 64'(e_eq));
        check("gt", 64'(gt), 64'(e_gt));
        check("out", out, 64'(e_lt));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_flags", {61'd0, lt, eq, gt}, {61'd0, e_lt, e_eq, e_gt});
            check("bp_out", out, 64'(e_lt));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("retire_valid", 64'(out_valid), 64'd0);
        check("retire_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] x, y;
        int          sel;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_flags", {61'd0, lt, eq, gt}, 64'd0);
        check("rst_out", out, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_cmp(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 0);
        do_cmp(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1, 0);
        do_cmp(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b0, 0);
        do_cmp(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4554, 1'b0, 0);
        do_cmp(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
        do_cmp(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0);
        do_cmp(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4554, 1'b0, 5);

        // Reset during RUN on the third cycle after accept.
        a = 64'h1111_2222_3333_4444; b = a; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_flags", {61'd0, lt, eq, gt}, 64'd0);
        check("abort_out", out, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < int'(N) + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) check("abort_no_result", 64'(out_valid), 64'd0);
        end
        check("abort_idle", 64'(out_valid), 64'd0);
        do_cmp(64'hFFFF_0000_1234_5678, 64'h0000_FFFF_1234_5678, 1'b1, 1);

        for (int t = 0; t < 40; t++) begin
            x = {$urandom, $urandom};
            sel = $urandom_range(0, 3);
            case (sel)
                0: y = {$urandom, $urandom};
                1: y = x;
                2: y = x ^ (64'(8'($urandom_range(1, 255))) << (8 * $urandom_range(0, 7)));
                default: begin
                    x[63] = 1'b1;
                    y = {1'b0, 63'(x[62:0] ^ 63'($urandom_range(0, 3)))};
                end
            endcase
            do_cmp(x, y, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
